spi_slave_word: RTL and testbench

Parametrised SPI slave for the icestick SPI path, successor to the fixed 8-bit slave. It oversamples SCLK, MOSI, CE0 and CE1 in the `clk` domain and supports any word width and any of the four CPOL/CPHA modes. It accepts multi-word frames on either chip enable and hands each received word to fabric logic, such as the counter, with a one-cycle valid strobe. Transmit words are double-buffered through a load/pending handshake.

---
 rtl/spi_slave_word.sv | 144 ++++++++++++++
 tb/tb_spi_slave_word.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_word.sv
// Oversampled SPI slave: any WIDTH, any CPOL/CPHA, multi-word frames on CE0/CE1, double-buffered tx.
// Optional `SPI_ECHO_EN: on tx underrun the master gets back the most recent received word.
module spi_slave_word #(
  parameter int WIDTH = 8,
  parameter bit CPOL  = 1'b0,
  parameter bit CPHA  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SCLK,
  input  logic             MOSI,
  input  logic             CE0,
  input  logic             CE1,
  output logic             MISO,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_cs,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_pending,
  output logic             tx_underrun,
  output logic             frame_abort
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [1:0] sclk_q, mosi_q, ce0_q, ce1_q;
  logic       sclk_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= {2{CPOL}};
      mosi_q <= '0;
      ce0_q  <= '1;
      ce1_q  <= '1;
      sclk_d <= CPOL;
    end else begin
      sclk_q <= {sclk_q[0], SCLK};
      mosi_q <= {mosi_q[0], MOSI};
      ce0_q  <= {ce0_q[0], CE0};
      ce1_q  <= {ce1_q[0], CE1};
      sclk_d <= sclk_q[1];
    end
  end

  logic sclk_s, mosi_s, ce0_s, ce1_s;
  assign sclk_s = sclk_q[1];
  assign mosi_s = mosi_q[1];
  assign ce0_s  = ce0_q[1];
  assign ce1_s  = ce1_q[1];

  // Leading edge is the one moving SCLK away from its idle level.
  logic toggle, lead, sample, shift;
  assign toggle = sclk_s ^ sclk_d;
  assign lead   = toggle & (sclk_s ^ CPOL);
  assign sample = CPHA ? (toggle & ~lead) : lead;
  assign shift  = CPHA ? lead : (toggle & ~lead);

  state_t           state;
  logic             sel;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rx_shift, tx_shift, tx_buf;
  logic [WIDTH-1:0] rx_next, dflt, word_sel;
  logic             ce_mine, live, start, done, reload, take;

  assign ce_mine = sel ? ce1_s : ce0_s;
  assign live    = (state == ACTIVE) && !ce_mine;
  assign start   = (state == IDLE) && (ce0_s != ce1_s);
  assign done    = live && sample && (cnt == LAST);
  // CPHA=1 reloads on the completing sample edge; CPHA=0 on the next shift edge (counter already wrapped).
  assign reload  = live && (CPHA ? done : (shift && cnt == '0));
  assign take    = start || reload;
  assign rx_next = {rx_shift[WIDTH-2:0], mosi_s};

`ifdef SPI_ECHO_EN
  assign dflt = done ? rx_next : rx_data;
`else
  assign dflt = '0;
`endif

  assign word_sel = tx_pending ? tx_buf : (tx_load ? tx_data : dflt);
  assign MISO     = (state == ACTIVE) && tx_shift[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= 1'b0;
      cnt         <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_buf      <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_cs       <= 1'b0;
      tx_pending  <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_abort <= 1'b0;
      tx_underrun <= take && !tx_pending && !tx_load;

      // A load that coincides with a take of an empty buffer is bypassed, so it leaves nothing pending.
      if (tx_load) begin
        tx_buf <= tx_data;
        if (!(take && !tx_pending)) tx_pending <= 1'b1;
      end else if (take) begin
        tx_pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= ACTIVE;
            sel   <= ce0_s;
            cnt   <= '0;
          end
        end
        ACTIVE: begin
          if (ce_mine) begin
            state       <= IDLE;
            frame_abort <= (cnt != '0);
          end else begin
            if (sample) begin
              rx_shift <= rx_next;
              cnt      <= done ? '0 : cnt + 1'b1;
              if (done) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                rx_cs    <= sel;
              end
            end
            if (shift && cnt != '0) tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase

      if (take) tx_shift <= word_sel;
    end
  end
endmodule

// File: tb/tb_spi_slave_word.sv
// Bench for spi_slave_word: four instances (mode 0 W=8, modes 1/2/3 W=12) driven by a bit-level SPI master,
// checked against a word-level model of rx words, tx buffer takes, underruns and aborts.
module tb_spi_slave_word;
  localparam int N = 4;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]       sclk, mosi, ce0, ce1, tx_load;
  logic [N-1:0][11:0] tx_data;
  logic               miso [N];
  logic               rx_valid [N];
  logic               rx_cs [N];
  logic               tx_pending [N];
  logic               tx_underrun [N];
  logic               frame_abort [N];
  logic [11:0]        rx_data [N];

  for (genvar g = 0; g < N; g++) begin : gd
    localparam int W = (g == 0) ? 8 : 12;
    logic [W-1:0] rxd;
    spi_slave_word #(.WIDTH(W), .CPOL(1'(g >= 2)), .CPHA(1'(g == 1 || g == 3))) dut (
      .clk(clk), .rst(rst), .SCLK(sclk[g]), .MOSI(mosi[g]), .CE0(ce0[g]), .CE1(ce1[g]),
      .MISO(miso[g]), .rx_data(rxd), .rx_valid(rx_valid[g]), .rx_cs(rx_cs[g]),
      .tx_data(tx_data[g][W-1:0]), .tx_load(tx_load[g]), .tx_pending(tx_pending[g]),
      .tx_underrun(tx_underrun[g]), .frame_abort(frame_abort[g]));
    assign rx_data[g] = 12'(rxd);
  end

  typedef struct packed {logic [11:0] d; logic cs;} rxw_t;

  int n_chk = 0, n_fail = 0;
  rxw_t        exp_q [N][$];
  logic [11:0] m_buf [N];
  bit          m_pend [N];
  logic [11:0] m_last [N];
  bit          m_active [N];
  int          m_under [N], s_under [N], m_abort [N], s_abort [N], quiet [N];
  bit          prev_v [N];
  logic [11:0] mo_w [4], rx_m [4], ex_m [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model of one tx word selection (frame start or word reload).
  task automatic take(input int g, output logic [11:0] w);
    if (m_pend[g]) begin
      w = m_buf[g];
      m_pend[g] = 1'b0;
    end else begin
      m_under[g]++;
`ifdef SPI_ECHO_EN
      w = m_last[g];
`else
      w = '0;
`endif
    end
  endtask

  task automatic load(input int g, input logic [11:0] w);
    tx_data[g] = w;
    tx_load[g] = 1'b1;
    tick(1);
    tx_load[g] = 1'b0;
    m_buf[g] = w;
    m_pend[g] = 1'b1;
  endtask

  task automatic model_reset();
    for (int g = 0; g < N; g++) begin
      m_pend[g] = 1'b0;
      m_last[g] = '0;
      m_active[g] = 1'b0;
      exp_q[g].delete();
    end
  endtask

  // SPI master: clocks nbits of mo_w out on instance g, collecting MISO into rx_m.
  task automatic xfer(input int g, input bit cs, input int nbits, input bit rst_end);
    int w, k, b;
    bit cpol, cpha;
    w = (g == 0) ? 8 : 12;
    cpol = (g >= 2);
    cpha = (g == 1 || g == 3);
    for (int i = 0; i < 4; i++) begin
      rx_m[i] = '0;
      ex_m[i] = '0;
    end
    m_active[g] = 1'b1;
    if (cs) ce1[g] = 1'b0; else ce0[g] = 1'b0;
    take(g, ex_m[0]);
    tick(H);
    for (int i = 0; i < nbits; i++) begin
      k = i / w;
      b = w - 1 - (i % w);
      if (!cpha) begin
        mosi[g] = mo_w[k][b];
        tick(H);
        rx_m[k][b] = miso[g];
        sclk[g] = ~cpol;
        if (b == 0) begin
          exp_q[g].push_back('{d: mo_w[k], cs: cs});
          m_last[g] = mo_w[k];
        end
        tick(H);
        sclk[g] = cpol;
        if (b == 0) take(g, ex_m[k+1]);
      end else begin
        sclk[g] = ~cpol;
        mosi[g] = mo_w[k][b];
        tick(H);
        rx_m[k][b] = miso[g];
        sclk[g] = cpol;
        if (b == 0) begin
          exp_q[g].push_back('{d: mo_w[k], cs: cs});
          m_last[g] = mo_w[k];
          take(g, ex_m[k+1]);
        end
        tick(H);
      end
    end
    tick(H);
    ce0[g] = 1'b1;
    ce1[g] = 1'b1;
    m_active[g] = 1'b0;
    if (rst_end) begin
      rst = 1'b1;
      tick(1);
      check("rst_miso", 32'(miso[g]), 32'd0);
      check("rst_rx_data", 32'(rx_data[g]), 32'd0);
      check("rst_rx_valid", 32'(rx_valid[g]), 32'd0);
      check("rst_rx_cs", 32'(rx_cs[g]), 32'd0);
      check("rst_tx_pending", 32'(tx_pending[g]), 32'd0);
      check("rst_tx_underrun", 32'(tx_underrun[g]), 32'd0);
      check("rst_frame_abort", 32'(frame_abort[g]), 32'd0);
      rst = 1'b0;
      model_reset();
    end else if (nbits % w != 0) begin
      m_abort[g]++;
    end
    tick(8);
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (rx_valid[g]) begin
        check($sformatf("rx_valid_single[%0d]", g), 32'(prev_v[g]), 32'd0);
        if (exp_q[g].size() == 0) begin
          check($sformatf("rx_valid_expected[%0d]", g), 32'(rx_valid[g]), 32'd0);
        end else begin
          check($sformatf("rx_data[%0d]", g), 32'(rx_data[g]), 32'(exp_q[g][0].d));
          check($sformatf("rx_cs[%0d]", g), 32'(rx_cs[g]), 32'(exp_q[g][0].cs));
          void'(exp_q[g].pop_front());
        end
      end
      if (tx_underrun[g]) s_under[g]++;
      if (frame_abort[g]) s_abort[g]++;
      quiet[g] = m_active[g] ? 0 : quiet[g] + 1;
      if (quiet[g] >= 5) check($sformatf("miso_idle[%0d]", g), 32'(miso[g]), 32'd0);
      prev_v[g] = rx_valid[g];
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int g = 0; g < N; g++) begin
      sclk[g] = (g >= 2);
      mosi[g] = 1'b0;
      ce0[g] = 1'b1;
      ce1[g] = 1'b1;
      tx_load[g] = 1'b0;
      tx_data[g] = '0;
      m_under[g] = 0; s_under[g] = 0; m_abort[g] = 0; s_abort[g] = 0; quiet[g] = 0;
      prev_v[g] = 1'b0;
      m_buf[g] = '0;
    end
    model_reset();
    tick(3);
    for (int g = 0; g < N; g++) begin
      check($sformatf("init_miso[%0d]", g), 32'(miso[g]), 32'd0);
      check($sformatf("init_rx_data[%0d]", g), 32'(rx_data[g]), 32'd0);
      check($sformatf("init_rx_valid[%0d]", g), 32'(rx_valid[g]), 32'd0);
      check($sformatf("init_rx_cs[%0d]", g), 32'(rx_cs[g]), 32'd0);
      check($sformatf("init_tx_pending[%0d]", g), 32'(tx_pending[g]), 32'd0);
      check($sformatf("init_tx_underrun[%0d]", g), 32'(tx_underrun[g]), 32'd0);
      check($sformatf("init_frame_abort[%0d]", g), 32'(frame_abort[g]), 32'd0);
    end
    rst = 1'b0;
    tick(2);

    // Mode 0, single word on CE0.
    load(0, 12'hA5);
    tick(1);
    check("m0_pending_loaded", 32'(tx_pending[0]), 32'd1);
    mo_w[0] = 12'h3C;
    xfer(0, 1'b0, 8, 1'b0);
    check("m0_miso_model", 32'(rx_m[0]), 32'(ex_m[0]));
    check("m0_miso_lit", 32'(rx_m[0]), 32'hA5);
    check("m0_rx_data_lit", 32'(rx_data[0]), 32'h3C);
    check("m0_rx_cs_lit", 32'(rx_cs[0]), 32'd0);
    check("m0_pending_cleared", 32'(tx_pending[0]), 32'd0);

    // Modes 1/2/3, 12-bit on CE1.
    for (int g = 1; g < N; g++) begin
      load(g, 12'hABC);
      mo_w[0] = 12'hABC;
      xfer(g, 1'b1, 12, 1'b0);
      check($sformatf("m%0d_miso_model", g), 32'(rx_m[0]), 32'(ex_m[0]));
      check($sformatf("m%0d_miso_lit", g), 32'(rx_m[0]), 32'hABC);
      check($sformatf("m%0d_rx_data_lit", g), 32'(rx_data[g]), 32'hABC);
      check($sformatf("m%0d_rx_cs_lit", g), 32'(rx_cs[g]), 32'd1);
    end

    // Two-word frames with only the first tx word loaded.
    load(0, 12'h96);
    mo_w[0] = 12'h12;
    mo_w[1] = 12'h34;
    xfer(0, 1'b0, 16, 1'b0);
    check("w2_m0_miso0", 32'(rx_m[0]), 32'(ex_m[0]));
    check("w2_m0_miso1", 32'(rx_m[1]), 32'(ex_m[1]));
    check("w2_m0_miso0_lit", 32'(rx_m[0]), 32'h96);
`ifdef SPI_ECHO_EN
    check("w2_m0_miso1_lit", 32'(rx_m[1]), 32'h12);
`else
    check("w2_m0_miso1_lit", 32'(rx_m[1]), 32'h00);
`endif
    load(3, 12'h5C3);
    mo_w[0] = 12'h123;
    mo_w[1] = 12'h456;
    xfer(3, 1'b0, 24, 1'b0);
    check("w2_m3_miso0", 32'(rx_m[0]), 32'(ex_m[0]));
    check("w2_m3_miso1", 32'(rx_m[1]), 32'(ex_m[1]));
`ifdef SPI_ECHO_EN
    check("w2_m3_miso1_lit", 32'(rx_m[1]), 32'h123);
`else
    check("w2_m3_miso1_lit", 32'(rx_m[1]), 32'h000);
`endif
    check("w2_m3_rx_cs_lit", 32'(rx_cs[3]), 32'd0);

    // CE0 released after 5 bits, then a clean frame.
    mo_w[0] = 12'hFF;
    xfer(0, 1'b0, 5, 1'b0);
    check("abort_cnt_lit", 32'(s_abort[0]), 32'd1);
    load(0, 12'h7E);
    mo_w[0] = 12'h81;
    xfer(0, 1'b0, 8, 1'b0);
    check("after_abort_rx_lit", 32'(rx_data[0]), 32'h81);
    check("after_abort_miso", 32'(rx_m[0]), 32'(ex_m[0]));
    check("after_abort_miso_lit", 32'(rx_m[0]), 32'h7E);

    // Select conflict: both CEs low, SCLK toggling, nothing may happen.
    load(0, 12'h11);
    ce0[0] = 1'b0;
    ce1[0] = 1'b0;
    tick(H);
    for (int i = 0; i < 4; i++) begin
      mosi[0] = 1'b1;
      sclk[0] = 1'b1;
      tick(H);
      sclk[0] = 1'b0;
      tick(H);
    end
    ce0[0] = 1'b1;
    ce1[0] = 1'b1;
    tick(8);
    check("conflict_pending_kept", 32'(tx_pending[0]), 32'd1);
    check("conflict_rx_unchanged", 32'(rx_data[0]), 32'h81);

    // Overwrite pending word, reset mid-word, then a clean frame.
    load(0, 12'hC3);
    mo_w[0] = 12'hF0;
    xfer(0, 1'b0, 4, 1'b1);
    check("rst_partial_miso", 32'(rx_m[0]), 32'(ex_m[0] & 12'hF0));
    check("rst_partial_miso_lit", 32'(rx_m[0]), 32'hC0);
    load(0, 12'h66);
    mo_w[0] = 12'h5A;
    xfer(0, 1'b0, 8, 1'b0);
    check("post_rst_rx_lit", 32'(rx_data[0]), 32'h5A);
    check("post_rst_miso_lit", 32'(rx_m[0]), 32'h66);

    tick(10);
    check("underrun_cnt0_lit", 32'(s_under[0]), 32'd6);
    check("underrun_cnt3_lit", 32'(s_under[3]), 32'd3);
    for (int g = 0; g < N; g++) begin
      check($sformatf("rx_missing[%0d]", g), 32'(exp_q[g].size()), 32'd0);
      check($sformatf("underrun_cnt[%0d]", g), 32'(s_under[g]), 32'(m_under[g]));
      check($sformatf("abort_cnt[%0d]", g), 32'(s_abort[g]), 32'(m_abort[g]));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
